// File: rtl/ifetch_unit_if.sv
// Fetch-side bundle: imem address/data, execute redirect, and the decode handshake.
// The master modport is the fetch unit's view.
interface ifetch_unit_if;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;
  logic        fault;

  modport master (
    output iaddr, instr_valid, instr, instr_pc, misalign, fault,
    input  idata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  iaddr, instr_valid, instr, instr_pc, misalign, fault,
    output idata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: owns the fetch PC, captures imem data into a prefetch FIFO,
// hands instructions to decode, and handles redirects and out-of-range fetches.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus
);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) << 2;

  typedef enum logic {RUN, FAULT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] head;
  logic [PW:0]   count;
  logic          misalign_q;
  logic          fault_q;
  logic          full;
  logic          empty;
  logic          in_range;
  logic          push;
  logic          pop;

  always_comb begin
    full     = (count == (PW+1)'(FIFO_DEPTH));
    empty    = (count == '0);
    in_range = ({1'b0, fetch_pc} < LIMIT);
    push     = (state == RUN) && !bus.redirect_valid && !full && in_range;
    pop      = !empty && !bus.redirect_valid && bus.instr_ready;
    // When empty, show the most recently written slot so instr/instr_pc hold steady.
    head     = empty ? rd_ptr - PW'(1) : rd_ptr;
  end

  assign bus.iaddr       = fetch_pc;
  assign bus.instr_valid = !empty && !bus.redirect_valid;
  assign bus.instr       = data_q[head];
  assign bus.instr_pc    = pc_q[head];
  assign bus.misalign    = misalign_q;
  assign bus.fault       = fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      state      <= RUN;
      fetch_pc   <= {bus.redirect_pc[31:2], 2'b00};
      wr_ptr     <= rd_ptr;
      count      <= '0;
      misalign_q <= (bus.redirect_pc[1:0] != 2'b00);
      fault_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (push) begin
        data_q[wr_ptr] <= bus.idata;
        pc_q[wr_ptr]   <= fetch_pc;
        wr_ptr         <= wr_ptr + PW'(1);
        fetch_pc       <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW+1)'(1);
      end
      if (state == RUN && !in_range) begin
        state   <= FAULT;
        fault_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_unit_if bus();

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(32),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [32];
  initial for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + 32'(k);
  assign bus.idata = (bus.iaddr < 32'd128) ? mem[bus.iaddr[6:2]] : 32'hDEAD_BEEF;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: the FIFO is a queue of fetched PCs; instruction word at pc is 0x1000_0000 + pc/4.
  logic [31:0] m_pc;
  logic        m_fault;
  logic        m_mis;
  logic        m_ok = 1'b0;
  logic [31:0] m_q [$];
  logic        m_can_push;
  logic        m_do_pop;
  logic        exp_v;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_q.delete(); m_fault = 1'b0; m_mis = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (bus.redirect_valid) begin
        m_q.delete();
        m_pc    = {bus.redirect_pc[31:2], 2'b00};
        m_mis   = (bus.redirect_pc[1:0] != 2'b00);
        m_fault = 1'b0;
      end else begin
        m_can_push = !m_fault && (m_pc < 32'd128) && (m_q.size() < 2);
        m_do_pop   = (m_q.size() > 0) && bus.instr_ready;
        m_mis = 1'b0;
        if (!m_fault && m_pc >= 32'd128) m_fault = 1'b1;
        if (m_do_pop) void'(m_q.pop_front());
        if (m_can_push) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      exp_v = (m_q.size() > 0) && !bus.redirect_valid;
      chk("m_iaddr", bus.iaddr, m_pc);
      chk("m_instr_valid", 32'(bus.instr_valid), 32'(exp_v));
      if (exp_v) begin
        chk("m_instr_pc", bus.instr_pc, m_q[0]);
        chk("m_instr", bus.instr, 32'h1000_0000 + (m_q[0] >> 2));
      end
      chk("m_fault", 32'(bus.fault), 32'(m_fault));
      chk("m_misalign", 32'(bus.misalign), 32'(m_mis));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;

    // Streaming with decode always ready
    do_reset(); bus.instr_ready = 1'b1; #1;
    chk("t1_c0_valid", 32'(bus.instr_valid), 32'd0);
    tick(); #1;
    chk("t1_c1_valid", 32'(bus.instr_valid), 32'd1);
    chk("t1_c1_pc", bus.instr_pc, 32'h0);
    chk("t1_c1_instr", bus.instr, 32'h1000_0000);
    tick(); tick(); #1;
    chk("t1_c3_pc", bus.instr_pc, 32'h8);
    chk("t1_c3_instr", bus.instr, 32'h1000_0002);

    // Back-pressure fills the FIFO, then drains in order
    do_reset(); bus.instr_ready = 1'b0;
    repeat (4) tick(); #1;
    chk("t2_c4_iaddr", bus.iaddr, 32'h8);
    chk("t2_c4_valid", 32'(bus.instr_valid), 32'd1);
    chk("t2_c4_pc", bus.instr_pc, 32'h0);
    tick(); bus.instr_ready = 1'b1; #1;
    chk("t2_c5_pc", bus.instr_pc, 32'h0);
    tick(); #1; chk("t2_c6_pc", bus.instr_pc, 32'h4);
    tick(); #1; chk("t2_c7_pc", bus.instr_pc, 32'h8);
    tick(); #1;
    chk("t2_c8_pc", bus.instr_pc, 32'hC);
    chk("t2_c8_instr", bus.instr, 32'h1000_0003);

    // Redirect to 0x40 while the FIFO is full
    do_reset(); bus.instr_ready = 1'b0;
    repeat (6) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; #1;
    chk("t3_c6_valid", 32'(bus.instr_valid), 32'd0);
    tick(); bus.redirect_valid = 1'b0; bus.instr_ready = 1'b1; #1;
    chk("t3_c7_valid", 32'(bus.instr_valid), 32'd0);
    chk("t3_c7_iaddr", bus.iaddr, 32'h40);
    tick(); #1;
    chk("t3_c8_valid", 32'(bus.instr_valid), 32'd1);
    chk("t3_c8_pc", bus.instr_pc, 32'h40);
    chk("t3_c8_instr", bus.instr, 32'h1000_0010);
    chk("t3_c8_mis", 32'(bus.misalign), 32'd0);

    // Misaligned redirect
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h22; #1;
    chk("t4_valid", 32'(bus.instr_valid), 32'd0);
    tick(); bus.redirect_valid = 1'b0; #1;
    chk("t4_mis_hi", 32'(bus.misalign), 32'd1);
    chk("t4_iaddr", bus.iaddr, 32'h20);
    tick(); #1;
    chk("t4_mis_lo", 32'(bus.misalign), 32'd0);
    chk("t4_pc", bus.instr_pc, 32'h20);
    chk("t4_instr", bus.instr, 32'h1000_0008);

    // Run off the end of imem, then recover
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h70;
    tick(); bus.redirect_valid = 1'b0; #1;
    chk("t5_iaddr", bus.iaddr, 32'h70);
    tick(); #1; chk("t5_pc70", bus.instr_pc, 32'h70);
    repeat (3) tick(); #1;
    chk("t5_pc7c", bus.instr_pc, 32'h7C);
    chk("t5_instr7c", bus.instr, 32'h1000_001F);
    chk("t5_fault_pre", 32'(bus.fault), 32'd0);
    chk("t5_iaddr80", bus.iaddr, 32'h80);
    tick(); #1;
    chk("t5_fault", 32'(bus.fault), 32'd1);
    chk("t5_novalid", 32'(bus.instr_valid), 32'd0);
    tick(); #1;
    chk("t5_fault_hold", 32'(bus.fault), 32'd1);
    chk("t5_iaddr_hold", bus.iaddr, 32'h80);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
    tick(); bus.redirect_valid = 1'b0; #1;
    chk("t5_fault_clr", 32'(bus.fault), 32'd0);
    tick(); #1;
    chk("t5_rec_valid", 32'(bus.instr_valid), 32'd1);
    chk("t5_rec_pc", bus.instr_pc, 32'h0);

    // Redirect during push+pop, then reset mid-stream
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h12; #1;
    chk("t6_valid", 32'(bus.instr_valid), 32'd0);
    tick(); bus.redirect_valid = 1'b0; rst_n = 1'b0; #1;
    chk("t6_mis", 32'(bus.misalign), 32'd1);
    tick(); #1;
    chk("t6_rst_fault", 32'(bus.fault), 32'd0);
    chk("t6_rst_mis", 32'(bus.misalign), 32'd0);
    chk("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_rst_instr", bus.instr, 32'h0);
    chk("t6_rst_pc", bus.instr_pc, 32'h0);
    chk("t6_rst_iaddr", bus.iaddr, 32'h0);
    rst_n = 1'b1;
    tick(); #1;
    chk("t6_restart_pc", bus.instr_pc, 32'h0);
    chk("t6_restart_valid", 32'(bus.instr_valid), 32'd1);

    // Out-of-range redirect target faults one cycle later
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    tick(); bus.redirect_valid = 1'b0; #1;
    chk("t7_fault0", 32'(bus.fault), 32'd0);
    tick(); #1;
    chk("t7_fault1", 32'(bus.fault), 32'd1);
    chk("t7_novalid", 32'(bus.instr_valid), 32'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end for the RV32I core; it is the initiator side of the instruction-memory interface.
- Owns the fetch PC, drives the word address to imem, and captures the combinational read data into a small prefetch FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Accepts redirects from execute for branches and jumps, and flags fetches that fall outside the populated instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- IMEM_WORDS, 32, number of populated 32-bit words in imem; valid byte range is 0 .. IMEM_WORDS*4-1.
- FIFO_DEPTH, 2, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- iaddr  out  32  byte address to imem, always equal to fetch_pc; bits [1:0] always 0.
- idata  in  32  instruction word from imem, valid combinationally in the same cycle as iaddr.
- redirect_valid  in  1  one-cycle request to change the fetch stream.
- redirect_pc  in  32  target byte address of the redirect.
- instr_valid  out  1  head-of-FIFO entry is valid.
- instr_ready  in  1  decode accepts the entry; a transfer occurs when instr_valid && instr_ready.
- instr  out  32  head instruction word.
- instr_pc  out  32  byte address of the head instruction.
- misalign  out  1  one-cycle pulse: the accepted redirect had redirect_pc[1:0] != 0.
- fault  out  1  sticky: fetch_pc is out of the populated range.

Behaviour:
- Reset (rst_n==0 at an edge):
  - fetch_pc <= RESET_PC; FIFO count <= 0; state <= RUN.
  - misalign <= 0; fault <= 0.
  - Outputs during and after reset: instr_valid=0, instr=0, instr_pc=0.
  - Reset overrides redirect and any in-flight fetch or transfer.
- States: RUN, FAULT.
- RUN, push condition: no redirect_valid AND FIFO not full. When it holds, at the edge the FIFO pushes {idata, fetch_pc} and fetch_pc <= fetch_pc + 4, with 32-bit wrap and no carry out.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - Full with no pop: no push; fetch_pc holds.
  - Full with a pop in the same cycle: push is still blocked (the full check uses the registered count), so fill runs 1 entry per cycle and steady-state throughput is 1 instr/cycle only while the FIFO is not full.
- Range check, evaluated every cycle in RUN: if fetch_pc >= IMEM_WORDS*4 (unsigned), there is no push and the next state is FAULT with fault <= 1. Entries already in the FIFO remain poppable.
- FAULT:
  - No pushes; fetch_pc holds; fault stays 1.
  - Exit only by reset or by a redirect; a redirect returns to RUN and clears fault at the same edge. If the redirect target is itself out of range, the next cycle re-enters FAULT.
- Redirect (redirect_valid==1), highest priority after reset, valid in any state:
  - instr_valid is forced to 0 combinationally that cycle, so no transfer occurs.
  - At the edge: FIFO flushed to count 0; fetch_pc <= {redirect_pc[31:2],2'b00}; misalign <= (redirect_pc[1:0]!=0), for one cycle.
  - Nothing is pushed in the redirect cycle.
- Latency:
  - Redirect asserted in cycle n: iaddr = target in cycle n+1, and instr_valid with instr_pc = target in cycle n+2.
  - Reset released before cycle 0: the first instr_valid is in cycle 1.
- Outputs:
  - instr, instr_pc and instr_valid come from registered FIFO storage (head entry); no combinational path from idata to instr.
  - When the FIFO is empty, instr and instr_pc hold their last values; the bench must not check them then.
- Back-to-back redirects: each is honoured; the last one wins.
- The FIFO never overflows or underflows. A pop on empty is impossible because instr_valid=0.

Test Plan:
- Reset then instr_ready=1 constantly, imem preloaded with word k = 32'h1000_0000+k -> instr_valid rises in cycle 1; instr_pc 0,4,8,... each cycle with instr = 0x1000_0000, 0x1000_0001, ...
- instr_ready=0 for 5 cycles after reset -> FIFO fills to 2 and stops; iaddr holds at 8; then raise ready -> instrs at pc 0,4,8,12 in order, none lost or duplicated.
- Redirect to 0x0000_0040 in cycle 6 while the FIFO holds 2 entries -> instr_valid=0 in cycles 6 and 7; cycle 8 instr_pc=0x40, instr=word 16; misalign stays 0.
- Redirect to 0x0000_0022 -> misalign pulses 1 for exactly one cycle; the next delivered instr_pc=0x20.
- Run sequentially to pc 0x7C with IMEM_WORDS=32 -> the instr at 0x7C is delivered; fetch_pc=0x80 sets fault=1 with no further instr_valid; a redirect to 0x0 clears fault and the instr at 0x0 is delivered 2 cycles later.
- Redirect asserted in the same cycle as a pop and a push, then rst_n=0 mid-stream -> no transfer in the redirect cycle; after reset, fault=0, misalign=0, count=0 and fetch restarts at RESET_PC.
